// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the 5-stage MIPS core.
// Owns the PC and remembers a redirect that shows up while instruction memory is busy.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        mem_stall,
   input  logic        PCSrc,
   input  logic        IF_Flush,
   input  logic        Jump,
   input  logic        JumpR,
   input  logic [31:0] branch_target,
   input  logic [31:0] jr_target,
   input  logic [25:0] jump_index,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IFID_pc4,
   output logic [31:0] IFID_inst,
   output logic        IFID_valid,
   output logic        redirect_pend
);

   typedef enum logic {RUN, PEND} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pend_target;
   logic [31:0] pc_plus4;
   logic [31:0] sel_target;
   logic        redirect;

   assign pc_plus4      = pc + 32'd4;
   assign redirect      = PCSrc | Jump | JumpR;
   assign imem_addr     = pc;
   assign redirect_pend = (state == PEND);

   // Register-indirect jumps beat direct jumps, which beat branches.
   always_comb begin
      sel_target = branch_target;
      if (JumpR)
         sel_target = jr_target;
      else if (Jump)
         sel_target = {IFID_pc4[31:28], jump_index, 2'b00};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         IFID_pc4    <= '0;
         IFID_inst   <= '0;
         IFID_valid  <= 1'b0;
         state       <= RUN;
         pend_target <= '0;
      end else if (mem_stall) begin
         // Only the first redirect seen during a memory stall is kept.
         if (state == RUN && redirect && !stall) begin
            state       <= PEND;
            pend_target <= sel_target;
         end
      end else if (!stall) begin
         if (state == PEND) begin
            pc         <= pend_target;
            IFID_pc4   <= '0;
            IFID_inst  <= '0;
            IFID_valid <= 1'b0;
            state      <= RUN;
         end else if (redirect) begin
            pc         <= sel_target;
            IFID_pc4   <= '0;
            IFID_inst  <= '0;
            IFID_valid <= 1'b0;
         end else if (IF_Flush) begin
            pc         <= pc_plus4;
            IFID_pc4   <= '0;
            IFID_inst  <= '0;
            IFID_valid <= 1'b0;
         end else begin
            pc         <= pc_plus4;
            IFID_pc4   <= pc_plus4;
            IFID_inst  <= imem_rdata;
            IFID_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the driver queues expected post-edge state, and a
// negedge monitor pops and compares it against the DUT outputs.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        mem_stall;
   logic        PCSrc;
   logic        IF_Flush;
   logic        Jump;
   logic        JumpR;
   logic [31:0] branch_target;
   logic [31:0] jr_target;
   logic [25:0] jump_index;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] IFID_pc4;
   logic [31:0] IFID_inst;
   logic        IFID_valid;
   logic        redirect_pend;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
      logic        pend;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   driverDone = 0;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .mem_stall     (mem_stall),
      .PCSrc         (PCSrc),
      .IF_Flush      (IF_Flush),
      .Jump          (Jump),
      .JumpR         (JumpR),
      .branch_target (branch_target),
      .jr_target     (jr_target),
      .jump_index    (jump_index),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .IFID_pc4      (IFID_pc4),
      .IFID_inst     (IFID_inst),
      .IFID_valid    (IFID_valid),
      .redirect_pend (redirect_pend)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic setIdle();
      rst           = 1'b0;
      stall         = 1'b0;
      mem_stall     = 1'b0;
      PCSrc         = 1'b0;
      IF_Flush      = 1'b0;
      Jump          = 1'b0;
      JumpR         = 1'b0;
      branch_target = '0;
      jr_target     = '0;
      jump_index    = '0;
      imem_rdata    = '0;
   endtask

   // Inputs are already set; clock one edge and queue the state expected after it.
   task automatic applyStimulus(input string name, input logic [31:0] addr,
                                input logic [31:0] inst, input logic [31:0] pc4,
                                input logic valid, input logic pend);
      exp_t e;
      @(posedge clk);
      e.name  = name;
      e.addr  = addr;
      e.inst  = inst;
      e.pc4   = pc4;
      e.valid = valid;
      e.pend  = pend;
      expQ.push_back(e);
      #1;
   endtask

   task automatic cmpField(input string name, input string field,
                           input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmpField(e.name, "imem_addr", imem_addr, e.addr);
      cmpField(e.name, "IFID_inst", IFID_inst, e.inst);
      cmpField(e.name, "IFID_pc4", IFID_pc4, e.pc4);
      cmpField(e.name, "IFID_valid", {31'b0, IFID_valid}, {31'b0, e.valid});
      cmpField(e.name, "redirect_pend", {31'b0, redirect_pend}, {31'b0, e.pend});
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : driver
      setIdle();
      rst = 1'b1;
      applyStimulus("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;

      // Sequential fetch from 0 up to PC=0x40.
      for (int k = 0; k < 16; k++) begin
         imem_rdata = 32'h2008_0001 + k;
         applyStimulus($sformatf("seq%0d", k), 32'(4 * (k + 1)), 32'h2008_0001 + k,
                       32'(4 * (k + 1)), 1'b1, 1'b0);
      end

      // Taken branch with flush at PC=0x40.
      PCSrc = 1'b1; IF_Flush = 1'b1; branch_target = 32'h100; imem_rdata = 32'hDEAD_0000;
      applyStimulus("branch", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
      setIdle(); imem_rdata = 32'h8C09_0100;
      applyStimulus("branch_fetch", 32'h104, 32'h8C09_0100, 32'h104, 1'b1, 1'b0);

      // Build IFID_pc4=0x1000_0008, then Jump and JumpR together.
      JumpR = 1'b1; jr_target = 32'h1000_0004;
      applyStimulus("jr_setup", 32'h1000_0004, 32'h0, 32'h0, 1'b0, 1'b0);
      setIdle(); imem_rdata = 32'h0C00_0010;
      applyStimulus("jr_setup_fetch", 32'h1000_0008, 32'h0C00_0010, 32'h1000_0008, 1'b1, 1'b0);
      Jump = 1'b1; jump_index = 26'h000_0010; JumpR = 1'b1; jr_target = 32'h200;
      applyStimulus("jumpr_wins", 32'h200, 32'h0, 32'h0, 1'b0, 1'b0);

      setIdle(); JumpR = 1'b1; jr_target = 32'h1000_0004;
      applyStimulus("j_setup", 32'h1000_0004, 32'h0, 32'h0, 1'b0, 1'b0);
      setIdle(); imem_rdata = 32'h0C00_0010;
      applyStimulus("j_setup_fetch", 32'h1000_0008, 32'h0C00_0010, 32'h1000_0008, 1'b1, 1'b0);
      setIdle(); Jump = 1'b1; jump_index = 26'h000_0010;
      applyStimulus("jump", 32'h1000_0040, 32'h0, 32'h0, 1'b0, 1'b0);

      // Load-use stall ignores redirect and flush.
      setIdle(); imem_rdata = 32'h1040_0003;
      applyStimulus("pre_stall", 32'h1000_0044, 32'h1040_0003, 32'h1000_0044, 1'b1, 1'b0);
      stall = 1'b1; PCSrc = 1'b1; IF_Flush = 1'b1; branch_target = 32'h400; imem_rdata = 32'h5;
      applyStimulus("stall1", 32'h1000_0044, 32'h1040_0003, 32'h1000_0044, 1'b1, 1'b0);
      applyStimulus("stall2", 32'h1000_0044, 32'h1040_0003, 32'h1000_0044, 1'b1, 1'b0);
      stall = 1'b0; IF_Flush = 1'b0;
      applyStimulus("after_stall", 32'h400, 32'h0, 32'h0, 1'b0, 1'b0);

      // Memory stall captures the first redirect and keeps it through a load-use stall.
      setIdle(); imem_rdata = 32'h11;
      applyStimulus("pre_mstall", 32'h404, 32'h11, 32'h404, 1'b1, 1'b0);
      mem_stall = 1'b1; PCSrc = 1'b1; branch_target = 32'h300; imem_rdata = 32'h99;
      applyStimulus("mstall1", 32'h404, 32'h11, 32'h404, 1'b1, 1'b1);
      PCSrc = 1'b0; Jump = 1'b1; jump_index = 26'h000_0140;
      applyStimulus("mstall2", 32'h404, 32'h11, 32'h404, 1'b1, 1'b1);
      Jump = 1'b0;
      applyStimulus("mstall3", 32'h404, 32'h11, 32'h404, 1'b1, 1'b1);
      mem_stall = 1'b0; stall = 1'b1;
      applyStimulus("pend_stall", 32'h404, 32'h11, 32'h404, 1'b1, 1'b1);
      stall = 1'b0; Jump = 1'b1; jump_index = 26'h000_0140;
      applyStimulus("pend_resolve", 32'h300, 32'h0, 32'h0, 1'b0, 1'b0);

      // PC wrap at the top of the address space, then reset while pending.
      setIdle(); JumpR = 1'b1; jr_target = 32'hFFFF_FFFC;
      applyStimulus("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
      setIdle(); imem_rdata = 32'h22;
      applyStimulus("wrap", 32'h0, 32'h22, 32'h0, 1'b1, 1'b0);
      imem_rdata = 32'h23;
      applyStimulus("post_wrap", 32'h4, 32'h23, 32'h4, 1'b1, 1'b0);
      mem_stall = 1'b1; PCSrc = 1'b1; branch_target = 32'h700;
      applyStimulus("pend_before_rst", 32'h4, 32'h23, 32'h4, 1'b1, 1'b1);
      rst = 1'b1;
      applyStimulus("rst_in_pend", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      setIdle(); imem_rdata = 32'h33;
      applyStimulus("after_rst", 32'h4, 32'h33, 32'h4, 1'b1, 1'b0);
      driverDone = 1'b1;
   end

   initial begin : finisher
      wait (driverDone);
      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      if (expQ.size() > 0) begin
         mismatched++;
         $display("[TB] FAIL drain: %0d expected entries left, expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: driver unfinished, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It consumes the ID-stage control outputs PCSrc, IF_Flush, Jump and JumpR, and drives instruction memory.
- Owns the PC, computes PC+4, and selects the redirect target for branch, j/jal or jr/jalr.
- Holds on a load-use hazard stall or an instruction-memory stall. Captures a redirect that arrives during a memory stall so it is not lost.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  load-use hazard; hold PC and IF/ID
mem_stall  in  1  instruction memory busy; imem_rdata invalid this cycle
PCSrc  in  1  branch taken (beq resolved in ID)
IF_Flush  in  1  squash the instruction being fetched
Jump  in  1  j/jal in ID
JumpR  in  1  jr/jalr in ID
branch_target  in  32  branch target computed in ID
jr_target  in  32  rs value for jr/jalr
jump_index  in  26  instr[25:0] of ID instruction
imem_addr  out  32  fetch address (= PC register, combinational)
imem_rdata  in  32  fetched instruction
IFID_pc4  out  32  PC+4 of instruction in ID
IFID_inst  out  32  instruction in ID (32'h0 = nop)
IFID_valid  out  1  IFID_inst is a real instruction
redirect_pend  out  1  pending-redirect flag (debug/observability)

Behaviour:
- Reset (rst=1 at edge):
  - PC=RESET_PC, IFID_pc4=0, IFID_inst=0, IFID_valid=0.
  - redirect_pend=0, pend_target=0.
  - rst overrides every other input.
- redirect = PCSrc|Jump|JumpR.
- Target priority: JumpR > Jump > PCSrc.
  - JumpR: jr_target.
  - Jump: {IFID_pc4[31:28], jump_index, 2'b00}.
  - PCSrc: branch_target.
- PC+4: 32-bit add, wraps modulo 2^32. jr_target is used unmasked; no alignment check.
- States:
  - RUN (redirect_pend=0).
  - PEND (redirect_pend=1, pend_target valid).
- Per-cycle priority when rst=0:
  1. mem_stall=1:
     - PC and IF/ID hold.
     - In RUN with redirect=1 and stall=0: go to PEND, pend_target<=selected target.
     - In PEND: live redirect is ignored; the first captured target wins.
  2. mem_stall=0, stall=1:
     - PC and IF/ID hold.
     - redirect and IF_Flush are ignored, because ID operands are not valid yet and ID re-asserts after the stall.
     - PEND is retained.
  3. mem_stall=0, stall=0, PEND:
     - PC<=pend_target.
     - IF/ID<=nop (inst=0, valid=0, pc4=0).
     - Go to RUN. Live redirect this cycle is ignored.
  4. mem_stall=0, stall=0, RUN, redirect=1:
     - PC<=selected target.
     - IF/ID<=nop.
  5. mem_stall=0, stall=0, RUN, IF_Flush=1, redirect=0:
     - PC<=PC+4.
     - IF/ID<=nop.
  6. Otherwise:
     - PC<=PC+4.
     - IFID_pc4<=PC+4, IFID_inst<=imem_rdata, IFID_valid<=1.
- Latency:
  - Redirect seen in cycle N gives imem_addr=target in N+1; exactly one bubble in ID.
  - Sequential fetch issues one instruction per cycle.
- Reset in PEND clears the pending state; no redirect occurs afterwards.
- Outputs change only on clk edges, except imem_addr, which mirrors the PC register.

Test Plan:
1. Reset, then 4 clean cycles with imem_rdata=0x20080001+k:
   - imem_addr = 0, 4, 8, 12.
   - IFID_inst follows one cycle later; IFID_pc4 = 4, 8, 12; IFID_valid=1.
2. PC=0x40, PCSrc=1 and IF_Flush=1 with branch_target=0x100:
   - Next cycle imem_addr=0x100, IFID_inst=0, IFID_valid=0.
   - The cycle after, IFID_inst = word fetched at 0x100.
3. IFID_pc4=0x1000_0008, Jump=1, jump_index=26'h0000010, with JumpR=1 and jr_target=0x200 in the same cycle:
   - JumpR wins, so imem_addr=0x200.
   - Repeat with JumpR=0: imem_addr=0x1000_0040.
4. stall=1 for 2 cycles while PCSrc=1:
   - PC and IF/ID are unchanged.
   - Redirect is not taken until PCSrc is applied after stall falls.
5. mem_stall=1 for 3 cycles, PCSrc=1 (target 0x300) only in the first, Jump=1 (target 0x500) in the second:
   - redirect_pend=1 holding 0x300.
   - After mem_stall falls: imem_addr=0x300, IF/ID nop, redirect_pend=0.
6. PC=0xFFFF_FFFC sequential fetch:
   - Next PC wraps to 0x0000_0000.
   - Assert rst while in PEND: PC=RESET_PC, redirect_pend=0, no redirect afterwards.
